mem_cal_supervisor: RTL and testbench
=====================================

Name: mem_cal_supervisor

Overview:
- Sits downstream of the Instrument_Unit memory subsystem and consumes its stats_local_init_done / stats_local_cal_success / stats_local_cal_fail status.
- Drives the subsystem's reset_reset_n and sequences reset, calibration wait and timeout handling.
- Retries bring-up up to a bounded count, then either declares memory ready and releases the user-logic reset, or latches a hard failure.

Parameters:
- RST_HOLD_CYCLES, 64, cycles ctrl_reset_n is held low per attempt (>=1)
- CAL_TIMEOUT_CYCLES, 1000000, max cycles in WAIT_CAL before the attempt counts as failed (>=1)
- MAX_RETRIES, 3, extra attempts after the first; total attempts = MAX_RETRIES+1
- SETTLE_CYCLES, 16, cycles of stable success before user_reset_n releases (>=1)

Ports:
- clk_clk  in  1  supervisor clock
- reset_reset_n  in  1  asynchronous active-low reset
- stats_local_init_done  in  1  from memory subsystem; asynchronous, synchronised internally
- stats_local_cal_success  in  1  from memory subsystem; asynchronous, synchronised internally
- stats_local_cal_fail  in  1  from memory subsystem; asynchronous, synchronised internally
- retry_req  in  1  single-cycle pulse; restarts bring-up from FAILED
- ctrl_reset_n  out  1  drives memory subsystem reset_reset_n
- user_reset_n  out  1  reset to user logic; high only when memory is ready
- mem_ready  out  1  memory calibrated and stable
- mem_failed  out  1  all attempts exhausted (sticky)
- attempt_cnt  out  4  attempts started, saturating at 15
- sup_state  out  3  FSM state encoding, for debug

Behaviour:
- Reset is asynchronous and active-low. On reset_reset_n low:
  - ctrl_reset_n=0, user_reset_n=0, mem_ready=0, mem_failed=0, attempt_cnt=0
  - state=HOLD_RST, all counters=0, synchroniser flops=0
- Synchronisation: each stats input passes through a 2-flop synchroniser. The FSM uses only synchronised values, so input-to-decision latency is 2 cycles.
- State encodings: HOLD_RST=0, WAIT_CAL=1, SETTLE=2, READY=3, BACKOFF=4, FAILED=5.
- HOLD_RST:
  - ctrl_reset_n=0; counter runs 0..RST_HOLD_CYCLES-1.
  - At terminal count: go to WAIT_CAL, clear counter, attempt_cnt+1 (saturating).
  - ctrl_reset_n goes 1 in the first WAIT_CAL cycle.
- WAIT_CAL (ctrl_reset_n=1, timeout counter runs):
  - sync cal_fail=1 -> BACKOFF. Fail has priority if success and fail are both high in the same cycle.
  - sync init_done=1 and cal_success=1 -> SETTLE.
  - Counter reaches CAL_TIMEOUT_CYCLES-1 with neither condition -> BACKOFF.
- SETTLE:
  - Requires init_done and cal_success continuously high for SETTLE_CYCLES.
  - Either drops, or cal_fail rises -> BACKOFF.
  - On completion -> READY.
- READY:
  - mem_ready=1 and user_reset_n=1, both registered and asserting in the first READY cycle.
  - Loss handling depends on the optional feature below.
- BACKOFF (one cycle):
  - ctrl_reset_n=0, mem_ready=0, user_reset_n=0.
  - If attempt_cnt <= MAX_RETRIES -> HOLD_RST; else -> FAILED.
- FAILED:
  - mem_failed=1, ctrl_reset_n=0, user_reset_n=0.
  - retry_req -> HOLD_RST, attempt_cnt=0, mem_failed=0 the next cycle.
  - retry_req is ignored in every other state.
- Timeout counter width = clog2(CAL_TIMEOUT_CYCLES)+1. It never wraps; it clears on every state entry.
- user_reset_n is never 1 while ctrl_reset_n is 0.
- Reset mid-operation: immediate return to the reset values above, regardless of state.

Optional Feature:
- Macro: MEMSUP_LOSS_MONITOR_EN.
- Defined: in READY, sync cal_success=0 or cal_fail=1 -> BACKOFF.
  - user_reset_n and mem_ready drop the cycle after the transition.
  - This counts as a failed attempt.
- Undefined: READY is terminal until reset_reset_n; stats inputs are ignored in READY.

Decomposition:
- Package mem_sup_pkg holds:
  - state enum sup_state_t with the encodings above
  - SYNC_STAGES=2
  - ATTEMPT_W=4
- One sub-module: mem_sup_sync, an N-bit, 2-flop synchroniser with async active-low reset, instantiated once for the 3 stats bits.

Test Plan:
- Nominal bring-up (RST_HOLD_CYCLES=4, SETTLE_CYCLES=4): raise init_done+cal_success 10 cycles into WAIT_CAL -> SETTLE entered 2 cycles later; mem_ready=1 and user_reset_n=1 after 4 more cycles; attempt_cnt=1.
- Fail then pass: cal_fail pulse on attempt 1 -> BACKOFF; ctrl_reset_n low for 1+4 cycles; success on attempt 2 -> READY with attempt_cnt=2.
- Exhaustion (MAX_RETRIES=2, CAL_TIMEOUT_CYCLES=50, no success) -> 3 timeouts, each 50 cycles after WAIT_CAL entry; then FAILED with mem_failed=1 and attempt_cnt=3. retry_req -> HOLD_RST, attempt_cnt=0, then 1 on entry to WAIT_CAL.
- Glitch in SETTLE: drop cal_success for 1 cycle -> BACKOFF; user_reset_n stays 0 throughout.
- Simultaneous success and fail in WAIT_CAL -> BACKOFF, never SETTLE.
- With MEMSUP_LOSS_MONITOR_EN: drop cal_success in READY -> mem_ready=0 within 3 cycles, retry starts. Without the macro: mem_ready stays 1. In both builds, async reset mid-WAIT_CAL gives all outputs at reset values immediately.

Source files
------------

// File: rtl/mem_sup_pkg.sv
// Shared types and constants for the memory calibration supervisor.
// Feature macro used by the top: MEMSUP_LOSS_MONITOR_EN.
package mem_sup_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int ATTEMPT_W   = 4;

    typedef enum logic [2:0] {
        ST_HOLD_RST = 3'd0,
        ST_WAIT_CAL = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_READY    = 3'd3,
        ST_BACKOFF  = 3'd4,
        ST_FAILED   = 3'd5
    } sup_state_t;

    typedef struct packed {
        logic init_done;
        logic cal_success;
        logic cal_fail;
    } mem_stats_t;

    // Attempt counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ATTEMPT_W-1:0] sat_inc(input logic [ATTEMPT_W-1:0] v);
        logic [ATTEMPT_W-1:0] r;
        if (v == {ATTEMPT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(ATTEMPT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_sup_sync.sv
// N-bit multi-flop synchroniser for the asynchronous memory status bits.
module mem_sup_sync
    import mem_sup_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_r;

    // Shift the raw inputs through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r <= '0;
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/mem_cal_supervisor.sv
// Memory bring-up supervisor: reset hold, calibration wait, retries, ready/fail.
// Optional macro MEMSUP_LOSS_MONITOR_EN: drop out of READY on calibration loss.
module mem_cal_supervisor
    import mem_sup_pkg::*;
#(
    parameter int RST_HOLD_CYCLES    = 64,
    parameter int CAL_TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRIES        = 3,
    parameter int SETTLE_CYCLES      = 16
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic                 stats_local_init_done,
    input  logic                 stats_local_cal_success,
    input  logic                 stats_local_cal_fail,
    input  logic                 retry_req,
    output logic                 ctrl_reset_n,
    output logic                 user_reset_n,
    output logic                 mem_ready,
    output logic                 mem_failed,
    output logic [ATTEMPT_W-1:0] attempt_cnt,
    output logic [2:0]           sup_state
);

    localparam int TMO_W  = $clog2(CAL_TIMEOUT_CYCLES) + 1;
    localparam int PH_MAX = (RST_HOLD_CYCLES > SETTLE_CYCLES) ? RST_HOLD_CYCLES : SETTLE_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX) + 1;

    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(CAL_TIMEOUT_CYCLES - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST   = PH_W'(RST_HOLD_CYCLES - 1);
    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [31:0]      RETRY_LIMIT = 32'(MAX_RETRIES);

    logic [2:0]           stats_raw_s;
    logic [2:0]           stats_sync_vec_s;
    mem_stats_t           stats_s;
    logic                 cal_good_s;
    logic                 retry_ok_s;
    sup_state_t           state_r;
    sup_state_t           state_nxt_s;
    logic [PH_W-1:0]      ph_cnt_r;
    logic [TMO_W-1:0]     tmo_cnt_r;
    logic [ATTEMPT_W-1:0] attempt_r;
    logic                 ctrl_reset_n_r;
    logic                 user_reset_n_r;
    logic                 mem_ready_r;
    logic                 mem_failed_r;

    assign stats_raw_s = {stats_local_init_done, stats_local_cal_success, stats_local_cal_fail};

    mem_sup_sync #(
        .WIDTH (3)
    ) u_sync (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .d     (stats_raw_s),
        .q     (stats_sync_vec_s)
    );

    assign stats_s    = stats_sync_vec_s;
    assign cal_good_s = stats_s.init_done & stats_s.cal_success;
    assign retry_ok_s = ({{(32-ATTEMPT_W){1'b0}}, attempt_r} <= RETRY_LIMIT);

    // Next-state decision; cal_fail is checked first so it wins over success.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_HOLD_RST: begin
                if (ph_cnt_r == HOLD_LAST) begin
                    state_nxt_s = ST_WAIT_CAL;
                end else begin
                    state_nxt_s = ST_HOLD_RST;
                end
            end
            ST_WAIT_CAL: begin
                if (stats_s.cal_fail) begin
                    state_nxt_s = ST_BACKOFF;
                end else if (cal_good_s) begin
                    state_nxt_s = ST_SETTLE;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_nxt_s = ST_BACKOFF;
                end else begin
                    state_nxt_s = ST_WAIT_CAL;
                end
            end
            ST_SETTLE: begin
                if (stats_s.cal_fail || !cal_good_s) begin
                    state_nxt_s = ST_BACKOFF;
                end else if (ph_cnt_r == SETTLE_LAST) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_READY: begin
`ifdef MEMSUP_LOSS_MONITOR_EN
                if (!stats_s.cal_success || stats_s.cal_fail) begin
                    state_nxt_s = ST_BACKOFF;
                end else begin
                    state_nxt_s = ST_READY;
                end
`else
                state_nxt_s = ST_READY;
`endif
            end
            ST_BACKOFF: begin
                if (retry_ok_s) begin
                    state_nxt_s = ST_HOLD_RST;
                end else begin
                    state_nxt_s = ST_FAILED;
                end
            end
            ST_FAILED: begin
                if (retry_req) begin
                    state_nxt_s = ST_HOLD_RST;
                end else begin
                    state_nxt_s = ST_FAILED;
                end
            end
            default: begin
                state_nxt_s = ST_HOLD_RST;
            end
        endcase
    end

    // State, counters and outputs; outputs follow the destination state so they are valid on entry.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r        <= ST_HOLD_RST;
            ph_cnt_r       <= '0;
            tmo_cnt_r      <= '0;
            attempt_r      <= '0;
            ctrl_reset_n_r <= 1'b0;
            user_reset_n_r <= 1'b0;
            mem_ready_r    <= 1'b0;
            mem_failed_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;

            if (state_nxt_s != state_r) begin
                ph_cnt_r  <= '0;
                tmo_cnt_r <= '0;
            end else begin
                if (state_r == ST_HOLD_RST || state_r == ST_SETTLE) begin
                    ph_cnt_r <= ph_cnt_r + PH_W'(1);
                end else begin
                    ph_cnt_r <= ph_cnt_r;
                end
                if (state_r == ST_WAIT_CAL && tmo_cnt_r != TMO_LAST) begin
                    tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                end else begin
                    tmo_cnt_r <= tmo_cnt_r;
                end
            end

            if (state_r == ST_HOLD_RST && state_nxt_s == ST_WAIT_CAL) begin
                attempt_r <= sat_inc(attempt_r);
            end else if (state_r == ST_FAILED && state_nxt_s == ST_HOLD_RST) begin
                attempt_r <= '0;
            end else begin
                attempt_r <= attempt_r;
            end

            ctrl_reset_n_r <= (state_nxt_s == ST_WAIT_CAL) || (state_nxt_s == ST_SETTLE) ||
                              (state_nxt_s == ST_READY);
            user_reset_n_r <= (state_nxt_s == ST_READY);
            mem_ready_r    <= (state_nxt_s == ST_READY);
            mem_failed_r   <= (state_nxt_s == ST_FAILED);
        end
    end

    assign ctrl_reset_n = ctrl_reset_n_r;
    assign user_reset_n = user_reset_n_r;
    assign mem_ready    = mem_ready_r;
    assign mem_failed   = mem_failed_r;
    assign attempt_cnt  = attempt_r;
    assign sup_state    = state_r;

endmodule

// File: tb/tb_mem_cal_supervisor.sv
// Scoreboard bench for mem_cal_supervisor: expected state visits, dwell times and
// per-state outputs are queued with the stimulus and checked as the DUT moves.
module tb_mem_cal_supervisor;

    localparam int RST_HOLD = 4;
    localparam int TMO      = 50;
    localparam int RETRIES  = 2;
    localparam int SETTLE   = 4;
    // Two synchroniser flops, then the edge on which the FSM acts.
    localparam int SYNC_LAT = 3;

    localparam int S_HOLD    = 0;
    localparam int S_WAIT    = 1;
    localparam int S_SETTLE  = 2;
    localparam int S_READY   = 3;
    localparam int S_BACKOFF = 4;
    localparam int S_FAILED  = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_done = 1'b0;
    logic       cal_success = 1'b0;
    logic       cal_fail = 1'b0;
    logic       retry_req = 1'b0;
    logic       ctrl_reset_n;
    logic       user_reset_n;
    logic       mem_ready;
    logic       mem_failed;
    logic [3:0] attempt_cnt;
    logic [2:0] sup_state;
    logic [7:0] obs_pack;

    typedef struct {
        int st;
        int att;
        int dwell;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   last_st = 0;
    int   cur_st = 0;
    int   cur_att = 0;
    int   dwell = 0;

    mem_cal_supervisor #(
        .RST_HOLD_CYCLES    (RST_HOLD),
        .CAL_TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES        (RETRIES),
        .SETTLE_CYCLES      (SETTLE)
    ) dut (
        .clk_clk                 (clk),
        .reset_reset_n           (rst_n),
        .stats_local_init_done   (init_done),
        .stats_local_cal_success (cal_success),
        .stats_local_cal_fail    (cal_fail),
        .retry_req               (retry_req),
        .ctrl_reset_n            (ctrl_reset_n),
        .user_reset_n            (user_reset_n),
        .mem_ready               (mem_ready),
        .mem_failed              (mem_failed),
        .attempt_cnt             (attempt_cnt),
        .sup_state               (sup_state)
    );

    assign obs_pack = {ctrl_reset_n, user_reset_n, mem_ready, mem_failed, attempt_cnt};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_outs(input int st, input int att);
        logic ctrl;
        logic rdy;
        logic fld;
        ctrl = (st == S_WAIT) || (st == S_SETTLE) || (st == S_READY);
        rdy  = (st == S_READY);
        fld  = (st == S_FAILED);
        return {ctrl, rdy, rdy, fld, 4'(att)};
    endfunction

    task automatic push_exp(input int st, input int att, input int dw);
        exp_t e;
        e.st    = st;
        e.att   = att;
        e.dwell = dw;
        sb_q.push_back(e);
    endtask

    task automatic wait_state(input int st, input int budget);
        int n = 0;
        while (int'(sup_state) != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_state", 32'(sup_state), 32'(st));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        init_done   = 1'b0;
        cal_success = 1'b0;
        cal_fail    = 1'b0;
        retry_req   = 1'b0;
        rst_n       = 1'b0;
        #1;
        check_eq("reset_outputs", 32'(obs_pack), 32'd0);
        check_eq("reset_state", 32'(sup_state), 32'(S_HOLD));
        repeat (2) @(negedge clk);
        push_exp(S_WAIT, 1, -1);
        #2;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: pop on every state change, check outputs every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_st = S_HOLD;
            cur_st  = S_HOLD;
            cur_att = 0;
            dwell   = 0;
        end else begin
            if (int'(sup_state) != last_st) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_state", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("sb_state", 32'(sup_state), 32'(e.st));
                    if (e.dwell >= 0) begin
                        check_eq("sb_dwell", 32'(dwell), 32'(e.dwell));
                    end
                    cur_st  = e.st;
                    cur_att = e.att;
                end
                last_st = int'(sup_state);
                dwell   = 1;
            end else begin
                dwell++;
            end
            check_eq("outputs", 32'(obs_pack), 32'(exp_outs(cur_st, cur_att)));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no end expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        // Nominal bring-up
        do_reset();
        wait_state(S_WAIT, 20);
        repeat (10) @(negedge clk);
        init_done   = 1'b1;
        cal_success = 1'b1;
        push_exp(S_SETTLE, 1, 10 + SYNC_LAT);
        push_exp(S_READY, 1, SETTLE);
        wait_state(S_READY, 30);
        check_eq("nominal_attempt", 32'(attempt_cnt), 32'd1);
        repeat (2) @(negedge clk);
        cal_success = 1'b0;
`ifdef MEMSUP_LOSS_MONITOR_EN
        push_exp(S_BACKOFF, 1, 2 + SYNC_LAT);
        push_exp(S_HOLD, 1, 1);
        push_exp(S_WAIT, 2, RST_HOLD);
        repeat (3) @(negedge clk);
        check_eq("loss_ready_drop", 32'(mem_ready), 32'd0);
        wait_state(S_WAIT, 20);
`else
        repeat (8) @(negedge clk);
        check_eq("ready_terminal", 32'({mem_ready, user_reset_n}), 32'd3);
`endif

        // Fail on attempt 1, pass on attempt 2
        do_reset();
        wait_state(S_WAIT, 20);
        repeat (5) @(negedge clk);
        cal_fail = 1'b1;
        push_exp(S_BACKOFF, 1, 5 + SYNC_LAT);
        push_exp(S_HOLD, 1, 1);
        push_exp(S_WAIT, 2, RST_HOLD);
        @(negedge clk);
        cal_fail = 1'b0;
        wait_state(S_BACKOFF, 10);
        wait_state(S_WAIT, 20);
        init_done   = 1'b1;
        cal_success = 1'b1;
        push_exp(S_SETTLE, 2, SYNC_LAT);
        push_exp(S_READY, 2, SETTLE);
        wait_state(S_READY, 30);
        check_eq("retry_pass_attempt", 32'(attempt_cnt), 32'd2);

        // Exhaustion by timeouts, retry_req ignored outside FAILED
        do_reset();
        for (int a = 1; a <= RETRIES + 1; a++) begin
            push_exp(S_BACKOFF, a, TMO);
            if (a <= RETRIES) begin
                push_exp(S_HOLD, a, 1);
                push_exp(S_WAIT, a + 1, RST_HOLD);
            end
        end
        push_exp(S_FAILED, RETRIES + 1, 1);
        wait_state(S_WAIT, 20);
        repeat (3) @(negedge clk);
        retry_req = 1'b1;
        @(negedge clk);
        retry_req = 1'b0;
        wait_state(S_FAILED, 3 * (TMO + RST_HOLD + 1) + 20);
        repeat (4) @(negedge clk);
        check_eq("failed_sticky", 32'({mem_failed, attempt_cnt}), 32'({1'b1, 4'd3}));
        retry_req = 1'b1;
        push_exp(S_HOLD, 0, 5);
        push_exp(S_WAIT, 1, RST_HOLD);
        @(negedge clk);
        retry_req = 1'b0;
        check_eq("retry_clears", 32'({mem_failed, attempt_cnt}), 32'd0);
        wait_state(S_WAIT, 20);
        check_eq("retry_attempt_one", 32'(attempt_cnt), 32'd1);

        // One-cycle success glitch in SETTLE
        do_reset();
        wait_state(S_WAIT, 20);
        init_done   = 1'b1;
        cal_success = 1'b1;
        push_exp(S_SETTLE, 1, SYNC_LAT);
        wait_state(S_SETTLE, 10);
        cal_success = 1'b0;
        push_exp(S_BACKOFF, 1, SYNC_LAT);
        push_exp(S_HOLD, 1, 1);
        push_exp(S_WAIT, 2, RST_HOLD);
        push_exp(S_SETTLE, 2, 1);
        push_exp(S_READY, 2, SETTLE);
        @(negedge clk);
        cal_success = 1'b1;
        wait_state(S_READY, 60);

        // Simultaneous success and fail in WAIT_CAL
        do_reset();
        wait_state(S_WAIT, 20);
        init_done   = 1'b1;
        cal_success = 1'b1;
        cal_fail    = 1'b1;
        push_exp(S_BACKOFF, 1, SYNC_LAT);
        push_exp(S_HOLD, 1, 1);
        push_exp(S_WAIT, 2, RST_HOLD);
        wait_state(S_BACKOFF, 10);
        init_done   = 1'b0;
        cal_success = 1'b0;
        cal_fail    = 1'b0;
        wait_state(S_WAIT, 20);
        repeat (5) @(negedge clk);

        // Asynchronous reset in the middle of WAIT_CAL
        do_reset();
        wait_state(S_WAIT, 20);
        repeat (3) @(negedge clk);
        #2;
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
